apb_slave_regbank: RTL and testbench
====================================

# apb_slave_regbank

APB completer that terminates one select line of the bridge's three-bit `psel` bus and backs it with a word-addressed register bank. It sits downstream of `bridge_top` and the APB interface stage, and answers the transfers the AHB master generates. It supplies programmable wait states through `pready`, read data on `pr_data` and, when configured, error responses on `pslverr`.

## Interface
- `SEL_IDX`, 0: index of the `psel` bit that selects this completer (0..2).
- `BASE_ADDR`, 32'h8000_0000: byte base address of the register window.
- `DEPTH`, 16: number of 32-bit registers; must be a power of two, 2..256.
- `WAIT_CYCLES`, 0: wait states inserted in every access phase (0..15).
- `hclk`  in  1  APB clock (same clock as the bridge); all state changes on the rising edge.
- `hresetn`  in  1  asynchronous, active-low reset.
- `psel`  in  3  one-hot slave select; only bit `SEL_IDX` is used.
- `penable`  in  1  APB enable; high in the access phase.
- `pwrite`  in  1  1 = write, 0 = read; stable from setup through completion.
- `paddr`  in  32  byte address; stable from setup through completion.
- `pwdata`  in  32  write data; sampled at completion.
- `pr_data`  out  32  read data; valid when `pready`=1 on a read.
- `pready`  out  1  transfer completes on this cycle.
- `pslverr`  out  1  error response; meaningful only while `pready`=1.

## Operation
- `sel` = `psel[SEL_IDX]`. The word index is `paddr[log2(DEPTH)+1:2]`.
- An address is in range when `paddr - BASE_ADDR < 4*DEPTH`, computed as a 32-bit unsigned subtraction so that addresses below the base wrap and count as out of range.
- State machine, Moore outputs:
  - IDLE: when `sel`=1 and `penable`=0 at the edge, go to ACCESS. Load `cnt` with `WAIT_CYCLES`. Latch `err`, the decoded error. On a read, load `pr_data` with `mem[index]`, or with 0 if `err`=1.
  - ACCESS: `pready` = (`cnt`==0). While `cnt`!=0 and `penable`=1, `cnt` decrements each edge.
    - Completion edge (`pready`=1, `penable`=1, `sel`=1): a write with `err`=0 commits `pwdata` to `mem[index]`. Go to IDLE.
  - Abort: in ACCESS, if `sel`=0 or `penable`=0 at an edge other than the first, go to IDLE with no write and no side effects.
- Back-to-back transfers: the setup phase of the next transfer follows the completion edge and is handled from IDLE. No idle cycle is required beyond what APB mandates.
- `pr_data` holds its last value between transfers. Writes do not change it.
- Writes and reads of the same register in consecutive transfers are coherent: a read sees the committed value.

## Timing
- Reset values: `pready`=0, `pslverr`=0, `pr_data`=0, all registers 0, state IDLE, `cnt`=0.
- Reset is asynchronous at any point. A transfer in flight is dropped and no write occurs.
- `pready` and `pslverr` depend only on registered state, with no combinational path from inputs.
- With `WAIT_CYCLES`=N, the access phase lasts N+1 cycles: `pready` rises N cycles after the first `penable` cycle.
- Write latency: the register updates on the completion edge and is readable by the next transfer's setup.
- `pslverr`=`err` & `pready`. It is 0 outside completion cycles.

## Configuration
- `APB_SLAVE_ERR_EN` defined:
  - `err` = misaligned (`paddr[1:0]`!=0) or out of range.
  - Errored transfers complete with `pslverr`=1 and `pr_data`=0, and writes are suppressed.
- Not defined:
  - `pslverr` is tied to 0.
  - Misaligned addresses use the word index and ignore `paddr[1:0]`.
  - Out-of-range writes are silently dropped; out-of-range reads return 0.
  - The wait-state timing is identical in both builds.

## Test plan
- Reset, then `WAIT_CYCLES`=0: write 32'hDEAD_BEEF to `BASE_ADDR`+8, then read the same address. Required: each transfer completes in 2 cycles, the read returns 32'hDEAD_BEEF, and `pslverr`=0.
- `WAIT_CYCLES`=3: read `BASE_ADDR`+4. Required: `pready` is low for 3 access cycles and high on the 4th, and `pr_data`=0 (the reset value).
- With `APB_SLAVE_ERR_EN` defined, write 32'h1234_5678 to each of:
  - `BASE_ADDR`+4*`DEPTH`,
  - `BASE_ADDR`-4,
  - `BASE_ADDR`+2.
  - Required: `pslverr`=1 with `pready`; a read of word 0 still returns its prior value; a read of `BASE_ADDR`+2 returns 0 with `pslverr`=1.
- Drop `penable` after 1 access cycle of a write with `WAIT_CYCLES`=2. Required: no write (a subsequent read returns the old value) and the state returns to IDLE.
- Assert `hresetn`=0 mid-access with `WAIT_CYCLES`=5, then release it. Required: `pready`/`pslverr`/`pr_data` = 0 immediately and all registers read 0. Also drive `psel` on a bit other than `SEL_IDX`. Required: no response, `pready` stays 0.

Source files
------------

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB completer with a word-addressed register bank.
// Responds to psel[SEL_IDX] and inserts WAIT_CYCLES wait states in every
// access phase.
// Optional feature macro: APB_SLAVE_ERR_EN. When defined, misaligned or
// out-of-window transfers complete with pslverr=1. When undefined, pslverr
// is tied low, misaligned addresses use the word index, and out-of-window
// accesses are silently dropped (writes) or read back as 0.

module apb_slave_regbank #(
  parameter int          SEL_IDX     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] pr_data,
  output logic        pready,
  output logic        pslverr
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [1:0]  SEL_BIT   = 2'(SEL_IDX);

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pready_q, pready_d;
  logic             pslverr_q, pslverr_d;
  logic [31:0]      pr_data_q, pr_data_d;
  logic [31:0]      mem_q [DEPTH];

  logic             sel;
  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] index;
  logic             decode_err;
  logic             wr_en;
  logic             unused_psel;

  // Only one select bit belongs to this completer; the rest are deliberately ignored.
  assign unused_psel = ^psel;
  assign sel         = psel[SEL_BIT];

  // Addresses below the base wrap to huge offsets and fall out of the window.
  assign offset   = paddr - BASE_ADDR;
  assign in_range = (offset < WIN_BYTES);
  assign index    = paddr[IDX_W+1:2];

`ifdef APB_SLAVE_ERR_EN
  assign decode_err = (paddr[1:0] != 2'b00) || !in_range;
`else
  assign decode_err = !in_range;
`endif

  // Next-state logic: setup capture, wait-state countdown, completion and abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pr_data_d = pr_data_q;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel && !penable) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_INIT;
          err_d   = decode_err;
          if (!pwrite) begin
            pr_data_d = decode_err ? 32'h0 : mem_q[index];
          end
        end
      end
      ST_ACCESS: begin
        if (!sel || !penable) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          wr_en   = pwrite && !err_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    pready_d = (state_d == ST_ACCESS) && (cnt_d == 4'd0);
`ifdef APB_SLAVE_ERR_EN
    pslverr_d = pready_d && err_d;
`else
    pslverr_d = 1'b0;
`endif
  end

  // Control and response registers; an asynchronous reset drops any transfer in flight.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      pr_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      pr_data_q <= pr_data_d;
    end
  end

  // Register bank: written only on an error-free write completion edge.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (wr_en) begin
      mem_q[index] <= pwdata;
    end
  end

  assign pr_data = pr_data_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank: drives two completers on one APB bus (different
// select bits and wait-state counts) with directed and random transfers and
// compares them against an array-based model of the register windows.
// Follows APB_SLAVE_ERR_EN the same way the design does.

module tb_apb_slave_regbank;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 16;
  localparam int          WAIT_A = 0;
  localparam int          WAIT_B = 3;
  localparam int          SEL_A  = 0;
  localparam int          SEL_B  = 2;
`ifdef APB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prDataA, prDataB;
  logic        readyA, readyB;
  logic        slverrA, slverrB;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] modelMem [2][DEPTH];
  logic [31:0] lastRd [2];

  apb_slave_regbank #(
    .SEL_IDX(SEL_A), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_A)
  ) dutA (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pr_data(prDataA), .pready(readyA), .pslverr(slverrA)
  );

  apb_slave_regbank #(
    .SEL_IDX(SEL_B), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_B)
  ) dutB (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pr_data(prDataB), .pready(readyB), .pslverr(slverrB)
  );

  always #5 hclk = ~hclk;

  // Hard stop in case something wedges the stimulus.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic readyOf(input int t);
    return (t == 0) ? readyA : readyB;
  endfunction

  function automatic logic errOf(input int t);
    return (t == 0) ? slverrA : slverrB;
  endfunction

  function automatic logic [31:0] dataOf(input int t);
    return (t == 0) ? prDataA : prDataB;
  endfunction

  function automatic int selOf(input int t);
    return (t == 0) ? SEL_A : SEL_B;
  endfunction

  function automatic int waitOf(input int t);
    return (t == 0) ? WAIT_A : WAIT_B;
  endfunction

  function automatic bit inWindow(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return off < 32'(4 * DEPTH);
  endfunction

  function automatic bit expectErr(input logic [31:0] addr);
    logic [1:0] low;
    low = addr[1:0];
    return ERR_EN && ((low != 2'b00) || !inWindow(addr));
  endfunction

  function automatic int wordOf(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE) >> 2;
    return int'(off[3:0]);
  endfunction

  task automatic clearModel();
    for (int t = 0; t < 2; t++) begin
      lastRd[t] = 32'h0;
      for (int i = 0; i < DEPTH; i++) modelMem[t][i] = 32'h0;
    end
  endtask

  task automatic busIdle();
    @(posedge hclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  // One APB transfer to target t. abortAfter>0 drops penable after that many
  // access cycles. Normal transfers leave the bus in the access phase so the
  // next call's first edge is the completion edge (back-to-back).
  task automatic applyStimulus(input string tag, input int t, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int abortAfter);
    int          waits      = 0;
    bit          done       = 1'b0;
    bit          otherSeen  = 1'b0;
    bit          lowErrSeen = 1'b0;
    bit          readySeen  = 1'b0;
    logic [31:0] obsData    = 32'h0;
    logic        obsErr     = 1'b0;
    logic [31:0] expData;
    int          ot         = 1 - t;
    bit          expE       = expectErr(addr);
    bit          hit        = inWindow(addr);

    @(posedge hclk); #1;
    psel    = 3'(1 << selOf(t));
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge hclk); #1;
    penable = 1'b1;

    if (abortAfter > 0) begin
      for (int c = 0; c < abortAfter; c++) begin
        @(negedge hclk);
        if (readyOf(t)) readySeen = 1'b1;
        @(posedge hclk); #1;
      end
      penable = 1'b0;
      @(negedge hclk);
      if (readyOf(t)) readySeen = 1'b1;
      @(posedge hclk); #1;
      psel = 3'b000;
      @(negedge hclk);
      if (readyOf(t)) readySeen = 1'b1;
      checkOutput({tag, "_abort_ready"}, 32'(readySeen), 32'h0);
      return;
    end

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge hclk);
      if (readyOf(ot)) otherSeen = 1'b1;
      if (readyOf(t)) begin
        obsData = dataOf(t);
        obsErr  = errOf(t);
        done    = 1'b1;
      end else begin
        if (errOf(t)) lowErrSeen = 1'b1;
        waits++;
        @(posedge hclk); #1;
      end
    end

    if (!done) begin
      checkOutput({tag, "_timeout"}, 32'(done), 32'h1);
    end else begin
      checkOutput({tag, "_waits"}, 32'(waits), 32'(waitOf(t)));
      checkOutput({tag, "_pslverr"}, 32'(obsErr), 32'(expE));
      if (!wr) begin
        expData = (expE || !hit) ? 32'h0 : modelMem[t][wordOf(addr)];
        checkOutput({tag, "_rdata"}, obsData, expData);
        lastRd[t] = expData;
      end else begin
        checkOutput({tag, "_prhold"}, obsData, lastRd[t]);
        if (hit && !expE) modelMem[t][wordOf(addr)] = wdata;
      end
    end
    checkOutput({tag, "_otherready"}, 32'(otherSeen), 32'h0);
    checkOutput({tag, "_slverrlow"}, 32'(lowErrSeen), 32'h0);
  endtask

  initial begin
    logic [31:0] addr;
    int          tgt;
    bit          wr;
    int          kind;
    int          abortAfter;
    bit          anyReady;

    hresetn = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    clearModel();
    repeat (3) @(posedge hclk);
    #1;
    checkOutput("rst_readyA", 32'(readyA), 32'h0);
    checkOutput("rst_slverrA", 32'(slverrA), 32'h0);
    checkOutput("rst_prdataA", prDataA, 32'h0);
    checkOutput("rst_readyB", 32'(readyB), 32'h0);
    checkOutput("rst_prdataB", prDataB, 32'h0);
    hresetn = 1'b1;

    // Zero-wait write then read of the same word.
    applyStimulus("a_wr8", 0, 1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 0);
    applyStimulus("a_rd8", 0, 1'b0, BASE + 32'd8, 32'h0, 0);

    // Three wait states, unwritten register reads as 0.
    applyStimulus("b_rd4", 1, 1'b0, BASE + 32'd4, 32'h0, 0);

    // Error / boundary addresses on A, then word 0 and the misaligned address.
    applyStimulus("a_wr0", 0, 1'b1, BASE, 32'hA5A5_0001, 0);
    applyStimulus("a_wrtop", 0, 1'b1, BASE + 32'(4 * DEPTH), 32'h1234_5678, 0);
    applyStimulus("a_wrlow", 0, 1'b1, BASE - 32'd4, 32'h1234_5678, 0);
    applyStimulus("a_wrmis", 0, 1'b1, BASE + 32'd2, 32'h1234_5678, 0);
    applyStimulus("a_rd0", 0, 1'b0, BASE, 32'h0, 0);
    applyStimulus("a_rdmis", 0, 1'b0, BASE + 32'd2, 32'h0, 0);
    applyStimulus("a_rdtop", 0, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 0);

    // Aborted write on B must leave the register untouched.
    applyStimulus("b_wr12", 1, 1'b1, BASE + 32'd12, 32'hCAFE_F00D, 0);
    applyStimulus("b_abort", 1, 1'b1, BASE + 32'd12, 32'h0BAD_0BAD, 1);
    applyStimulus("b_rd12", 1, 1'b0, BASE + 32'd12, 32'h0, 0);

    // Randomized traffic over both completers.
    for (int n = 0; n < 60; n++) begin
      tgt  = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind <= 6)      addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (kind == 7) addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      else if (kind == 8) addr = BASE - 32'(4 * $urandom_range(1, 4));
      else                addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      abortAfter = 0;
      if (tgt == 1 && wr && $urandom_range(0, 7) == 0) abortAfter = int'($urandom_range(1, 2));
      applyStimulus($sformatf("rnd%0d", n), tgt, wr, addr, $urandom, abortAfter);
    end

    // Select line that belongs to neither completer: nobody answers.
    busIdle();
    @(posedge hclk); #1;
    psel    = 3'b010;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = BASE;
    @(posedge hclk); #1;
    penable  = 1'b1;
    anyReady = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge hclk);
      if (readyA || readyB) anyReady = 1'b1;
    end
    checkOutput("foreign_sel_ready", 32'(anyReady), 32'h0);
    busIdle();

    // Make B's read data non-zero, then reset in the middle of a write.
    applyStimulus("b_rd12b", 1, 1'b0, BASE + 32'd12, 32'h0, 0);
    busIdle();
    @(posedge hclk); #1;
    psel    = 3'(1 << SEL_B);
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = BASE + 32'd20;
    pwdata  = 32'hFFFF_0000;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #2;
    hresetn = 1'b0;
    #1;
    checkOutput("midrst_readyB", 32'(readyB), 32'h0);
    checkOutput("midrst_slverrB", 32'(slverrB), 32'h0);
    checkOutput("midrst_prdataB", prDataB, 32'h0);
    checkOutput("midrst_prdataA", prDataA, 32'h0);
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    clearModel();
    applyStimulus("post_b12", 1, 1'b0, BASE + 32'd12, 32'h0, 0);
    applyStimulus("post_b20", 1, 1'b0, BASE + 32'd20, 32'h0, 0);
    applyStimulus("post_a8", 0, 1'b0, BASE + 32'd8, 32'h0, 0);
    applyStimulus("post_a0", 0, 1'b0, BASE, 32'h0, 0);
    busIdle();
    repeat (2) @(posedge hclk);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
